// File: rtl/ysyx_24100029_bp_pkg.sv
// Branch-predictor update path: shared defaults and queue record type.
// Contents:
//   BP_PHT_INDEX_WIDTH - default width of a PHT index
//   BP_GHR_WIDTH       - default global history length
//   bp_entry_t         - one resolved-branch record {pc_idx, taken} at default width
package ysyx_24100029_bp_pkg;

    localparam int BP_PHT_INDEX_WIDTH = 8;
    localparam int BP_GHR_WIDTH       = 8;

    typedef struct packed {
        logic [BP_PHT_INDEX_WIDTH-1:0] pc_idx;
        logic                          taken;
    } bp_entry_t;

endpackage

// File: rtl/ysyx_24100029_sync_fifo.sv
// Small synchronous FIFO used to buffer branch-update records.
// Ports:
//   clock, reset (async, active-low)
//   clear        - synchronous flush of pointers and occupancy (wins over push/pop)
//   push, wdata  - write at tail (ignored when full)
//   pop          - advance head (ignored when empty)
//   rdata        - combinational head entry
//   count, empty, full - occupancy status from registered state
// Payload storage carries no reset; only pointers and count are reset.
module ysyx_24100029_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests so an overflow or underflow can never corrupt state.
    always_comb begin
        empty     = (count_r == {CW{1'b0}});
        full      = (count_r == CW'(DEPTH));
        push_ok_s = push && !full && !clear;
        pop_ok_s  = pop && !empty && !clear;
        rdata     = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Payload write at the tail; contents need no reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_24100029_bp_update_queue.sv
// Branch predictor update queue: buffers resolved conditional branches from
// commit and drains them, one per cycle, into the PHT write port while
// maintaining the committed global history register (gshare indexing).
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_ready/in_pc/in_taken - resolved-branch record from commit
//   bp_hold   - pause PHT training (records stay queued, pushes continue)
//   bp_clear  - flush queue and history
//   fetch_pc  - PC being predicted; pht_index_r is its gshare read index
//   pht_w_en/pht_index_w/is_taken - PHT counter update port (zero when idle)
//   ghr       - committed global history
//   count     - queue occupancy
module ysyx_24100029_bp_update_queue
    import ysyx_24100029_bp_pkg::*;
#(
    parameter int PHT_INDEX_WIDTH = BP_PHT_INDEX_WIDTH,
    parameter int GHR_WIDTH       = BP_GHR_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic                       in_taken,
    input  logic                       bp_hold,
    input  logic                       bp_clear,
    input  logic [31:0]                fetch_pc,
    output logic [PHT_INDEX_WIDTH-1:0] pht_index_r,
    output logic                       pht_w_en,
    output logic [PHT_INDEX_WIDTH-1:0] pht_index_w,
    output logic                       is_taken,
    output logic [GHR_WIDTH-1:0]       ghr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int EW = PHT_INDEX_WIDTH + 1;

    // Same layout as bp_entry_t, sized by this instance's index width.
    typedef struct packed {
        logic [PHT_INDEX_WIDTH-1:0] pc_idx;
        logic                       taken;
    } entry_t;

    entry_t                     wr_entry_s;
    entry_t                     head_entry_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       push_s;
    logic [GHR_WIDTH-1:0]       ghr_r;
    logic [GHR_WIDTH-1:0]       ghr_next_s;
    logic [PHT_INDEX_WIDTH-1:0] ghr_ext_s;
    logic                       unused_pc_bits_s;

    // PC bits outside the index field are intentionally ignored.
    assign unused_pc_bits_s = ^{in_pc[31:PHT_INDEX_WIDTH+2], in_pc[1:0],
                                fetch_pc[31:PHT_INDEX_WIDTH+2], fetch_pc[1:0]};

    ysyx_24100029_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (bp_clear),
        .push  (push_s),
        .pop   (pht_w_en),
        .wdata (wr_entry_s),
        .rdata (head_entry_s),
        .count (count),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // History shift-in of the popped direction; a 1-bit history just takes the new bit.
    if (GHR_WIDTH == 1) begin : g_ghr_one
        assign ghr_next_s = head_entry_s.taken;
    end else begin : g_ghr_shift
        assign ghr_next_s = {ghr_r[GHR_WIDTH-2:0], head_entry_s.taken};
    end

    // Handshake, drain enable and gshare index formation (uses pre-shift history).
    always_comb begin
        wr_entry_s.pc_idx = in_pc[PHT_INDEX_WIDTH+1:2];
        wr_entry_s.taken  = in_taken;
        // Readiness depends only on registered occupancy, never on a same-cycle pop.
        in_ready          = !fifo_full_s && !bp_clear;
        push_s            = in_valid && in_ready;
        pht_w_en          = !fifo_empty_s && !bp_hold && !bp_clear;
        ghr_ext_s                = {PHT_INDEX_WIDTH{1'b0}};
        ghr_ext_s[GHR_WIDTH-1:0] = ghr_r;
        pht_index_r       = fetch_pc[PHT_INDEX_WIDTH+1:2] ^ ghr_ext_s;
        if (pht_w_en) begin
            pht_index_w = head_entry_s.pc_idx ^ ghr_ext_s;
            is_taken    = head_entry_s.taken;
        end else begin
            pht_index_w = {PHT_INDEX_WIDTH{1'b0}};
            is_taken    = 1'b0;
        end
        ghr = ghr_r;
    end

    // Committed global history register, advanced once per drained record.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_r <= {GHR_WIDTH{1'b0}};
        end else if (bp_clear) begin
            ghr_r <= {GHR_WIDTH{1'b0}};
        end else if (pht_w_en) begin
            ghr_r <= ghr_next_s;
        end else begin
            ghr_r <= ghr_r;
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_bp_update_queue.sv
// Self-checking bench for the branch-predictor update queue
// (PHT_INDEX_WIDTH=8, GHR_WIDTH=4, DEPTH=4).
module tb_ysyx_24100029_bp_update_queue;
    import ysyx_24100029_bp_pkg::*;

    localparam int PW = 8;
    localparam int GW = 4;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic          in_taken;
    logic          bp_hold;
    logic          bp_clear;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] pht_index_r;
    logic          pht_w_en;
    logic [PW-1:0] pht_index_w;
    logic          is_taken;
    logic [GW-1:0] ghr;
    logic [2:0]    count;

    int checks_n = 0;
    int errors_n = 0;

    // Reference model: a plain queue of records plus an integer history.
    bp_entry_t model_q[$];
    int        ghr_m;

    int rec_idx [5];
    int rec_tk  [5];

    ysyx_24100029_bp_update_queue #(
        .PHT_INDEX_WIDTH (PW),
        .GHR_WIDTH       (GW),
        .DEPTH           (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_taken    (in_taken),
        .bp_hold     (bp_hold),
        .bp_clear    (bp_clear),
        .fetch_pc    (fetch_pc),
        .pht_index_r (pht_index_r),
        .pht_w_en    (pht_w_en),
        .pht_index_w (pht_index_w),
        .is_taken    (is_taken),
        .ghr         (ghr),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hFF);
    endfunction

    task automatic compare_all();
        bit ready_e;
        bit wen_e;
        int idxw_e;
        int tk_e;
        ready_e = (model_q.size() != D) && !bp_clear;
        wen_e   = (model_q.size() != 0) && !bp_hold && !bp_clear;
        idxw_e  = wen_e ? (int'(model_q[0].pc_idx) ^ ghr_m) : 0;
        tk_e    = wen_e ? int'(model_q[0].taken) : 0;
        check("in_ready",    in_ready,    ready_e);
        check("pht_w_en",    pht_w_en,    wen_e);
        check("pht_index_w", pht_index_w, idxw_e);
        check("is_taken",    is_taken,    tk_e);
        check("pht_index_r", pht_index_r, pc_index(fetch_pc) ^ ghr_m);
        check("ghr",         ghr,         ghr_m);
        check("count",       count,       model_q.size());
    endtask

    task automatic model_edge();
        bit        ready_e;
        bit        wen_e;
        bp_entry_t h;
        bp_entry_t e;
        ready_e = (model_q.size() != D) && !bp_clear;
        wen_e   = (model_q.size() != 0) && !bp_hold && !bp_clear;
        if (bp_clear) begin
            model_q.delete();
            ghr_m = 0;
        end else begin
            if (wen_e) begin
                h     = model_q.pop_front();
                ghr_m = ((ghr_m << 1) | int'(h.taken)) & ((1 << GW) - 1);
            end
            if (in_valid && ready_e) begin
                e.pc_idx = in_pc[PW+1:2];
                e.taken  = in_taken;
                model_q.push_back(e);
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_pc    = 32'h0;
        in_taken = 1'b0;
        bp_hold  = 1'b0;
        bp_clear = 1'b0;
        fetch_pc = 32'h0;
        ghr_m    = 0;

        // Reset state
        @(posedge clock);
        #1;
        check("rst_count", count, 32'd0);
        check("rst_wen",   pht_w_en, 32'd0);
        #6 reset = 1'b1;
        @(posedge clock);
        #1;
        check("rel_count", count, 32'd0);
        check("rel_ghr",   ghr, 32'h0);
        check("rel_ready", in_ready, 32'd1);
        check("rel_wen",   pht_w_en, 32'd0);

        // Single record: visible on the write port the next cycle
        in_valid = 1'b1; in_pc = 32'h8000_0010; in_taken = 1'b1; fetch_pc = 32'h8000_0040;
        step();
        in_valid = 1'b0;
        check("one_wen", pht_w_en, 32'd1);
        check("one_idx", pht_index_w, 32'h04);
        check("one_tk",  is_taken, 32'd1);
        step();
        check("one_ghr",  ghr, 32'h1);
        check("one_idle", pht_w_en, 32'd0);

        // Back-to-back records of the same PC: history feeds the index
        bp_clear = 1'b1;
        step();
        bp_clear = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_taken = 1'b1;
        step();
        check("b2b_idx0", pht_index_w, 32'h00);
        step();
        check("b2b_idx1", pht_index_w, 32'h01);
        in_taken = 1'b0;
        step();
        check("b2b_idx2", pht_index_w, 32'h03);
        in_valid = 1'b0;
        step();
        check("b2b_ghr",   ghr, 32'h6);
        check("b2b_count", count, 32'd0);

        // Hold: five offered, four accepted, then drain in order
        bp_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_pc      = $urandom;
            in_taken   = 1'(i % 2);
            rec_idx[i] = pc_index(in_pc);
            rec_tk[i]  = i % 2;
            step();
        end
        in_valid = 1'b0;
        check("hold_count", count, 32'd4);
        check("hold_ready", in_ready, 32'd0);
        bp_hold = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_wen", pht_w_en, 32'd1);
            check("drain_tk",  is_taken, rec_tk[i]);
            check("drain_idx", {24'h0, pht_index_w ^ {4'h0, ghr}}, rec_idx[i]);
            step();
            if (i == 0) begin
                check("drain_ready", in_ready, 32'd1);
            end
        end
        check("drain_ghr", ghr, 32'h5);

        // Clear with a record offered: refused, queue and history flushed
        bp_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pc = $urandom; in_taken = 1'b1;
            step();
        end
        check("clr_pre_count", count, 32'd2);
        bp_clear = 1'b1;
        #1;
        check("clr_ready", in_ready, 32'd0);
        step();
        bp_clear = 1'b0; in_valid = 1'b0; bp_hold = 1'b0;
        #1;
        check("clr_count", count, 32'd0);
        check("clr_ghr",   ghr, 32'h0);
        check("clr_wen",   pht_w_en, 32'd0);
        step();

        // Asynchronous reset in the middle of a drain
        bp_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = $urandom; in_taken = 1'b1;
            step();
        end
        in_valid = 1'b0; bp_hold = 1'b0;
        #1;
        check("mid_wen",   pht_w_en, 32'd1);
        check("mid_count", count, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("arst_wen",   pht_w_en, 32'd0);
        check("arst_count", count, 32'd0);
        check("arst_idx",   pht_index_w, 32'h0);
        check("arst_tk",    is_taken, 32'd0);
        check("arst_ghr",   ghr, 32'h0);
        model_q.delete();
        ghr_m = 0;
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_pc    = $urandom;
            in_taken = 1'($urandom);
            fetch_pc = $urandom;
            bp_hold  = ($urandom_range(0, 9) < 2);
            bp_clear = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end

endmodule

// File: doc/ysyx_24100029_bp_update_queue.md
YSYX_24100029_BP_UPDATE_QUEUE -- requirements
Module: ysyx_24100029_bp_update_queue

Interface
REQ-001 Parameters SHALL be:
- PHT_INDEX_WIDTH, default 8, PHT index width.
- GHR_WIDTH, default 8, global history length; legal range 1..PHT_INDEX_WIDTH.
- DEPTH, default 4, queue entries; power of two, at least 2.

REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  resolved conditional branch record offered by commit.
- in_ready  out  1  queue can accept a record.
- in_pc  in  32  PC of the resolved branch.
- in_taken  in  1  resolved direction.
- bp_hold  in  1  suspend PHT training; queue holds its records.
- bp_clear  in  1  discard all queued records and clear history.
- fetch_pc  in  32  PC being predicted.
- pht_index_r  out  PHT_INDEX_WIDTH  read index to the PHT.
- pht_w_en  out  1  PHT counter update strobe.
- pht_index_w  out  PHT_INDEX_WIDTH  update index.
- is_taken  out  1  update direction.
- ghr  out  GHR_WIDTH  committed global history.
- count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-003 Push: a record SHALL be accepted on a rising edge where in_valid && in_ready; {in_pc[PHT_INDEX_WIDTH+1:2], in_taken} SHALL be written at the tail.
REQ-004 in_ready SHALL equal (count != DEPTH) && !bp_clear; it SHALL NOT depend on a same-cycle pop.
REQ-005 Drain: pht_w_en SHALL equal (count != 0) && !bp_hold && !bp_clear, combinationally from registered state.
REQ-006 While pht_w_en=1, pht_index_w SHALL equal head_pc_bits XOR zero-extended ghr (pre-update value), and is_taken SHALL equal head_taken.
REQ-007 On each edge with pht_w_en=1, the head SHALL be popped and ghr SHALL become {ghr[GHR_WIDTH-2:0], head_taken}.
REQ-008 pht_index_r SHALL equal fetch_pc[PHT_INDEX_WIDTH+1:2] XOR zero-extended ghr, using the current registered ghr (pre-shift in a drain cycle).
REQ-009 Latency: a record accepted at edge N SHALL be driven on the PHT write port in cycle N+1 at the earliest. Throughput SHALL be one update per cycle.
REQ-010 Ordering SHALL be strict FIFO; head/tail pointers SHALL wrap modulo DEPTH.
REQ-011 A simultaneous push and pop SHALL leave count unchanged. A push alone SHALL increment count; a pop alone SHALL decrement it.
REQ-012 When pht_w_en=0, pht_index_w and is_taken SHALL be 0.
REQ-013 bp_clear=1 at an edge SHALL set count, pointers and ghr to 0; no push or pop SHALL occur at that edge.
REQ-014 bp_hold SHALL block only pops; pushes SHALL continue until count equals DEPTH.

Reset
REQ-015 reset low SHALL immediately force count=0, pointers=0 and ghr=0; consequently in_ready=1 (when bp_clear=0), pht_w_en=0, pht_index_w=0 and is_taken=0.
REQ-016 Queue payload storage SHALL NOT require reset.
REQ-017 Assertion of reset mid-drain SHALL discard all records, with no partial update issued.

Structure
REQ-018 The package ysyx_24100029_bp_pkg SHALL hold the defaults for PHT_INDEX_WIDTH and GHR_WIDTH and the queue-entry struct typedef {pc_idx, taken}.
REQ-019 Storage SHALL be one sub-module, ysyx_24100029_sync_fifo (parameterised width and depth); the ghr register and index XOR logic SHALL live in the top module.

Verification (PHT_INDEX_WIDTH=8, GHR_WIDTH=4, DEPTH=4)
REQ-020 Release reset -> count=0, ghr=0x0, in_ready=1, pht_w_en=0.
REQ-021 Push pc=0x80000010 with taken=1 at edge 0 -> in cycle 1: pht_w_en=1, pht_index_w=0x04, is_taken=1; after edge 1: ghr=0x1, pht_w_en=0.
REQ-022 Back-to-back pushes of pc=0x80000000 with taken=1,1,0 -> pht_index_w=0x00, 0x01, 0x03 on consecutive cycles; final ghr=0x6.
REQ-023 With bp_hold=1, offer 5 records -> 4 accepted, count=4, in_ready=0. Release hold -> 4 updates on consecutive cycles in push order; in_ready=1 the cycle after the first pop.
REQ-024 With count=2, assert bp_clear for one cycle while in_valid=1 -> no accept; next cycle count=0, ghr=0x0, pht_w_en=0.
REQ-025 Assert reset while count=3 and pht_w_en=1 -> pht_w_en=0 and count=0 immediately, without waiting for a clock edge.
